// File: rtl/icache_mshr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | icache_mshr : instruction-cache miss status holding registers.           |
// | Merges multi-lane line misses, issues memory loads, delivers fills.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module icache_mshr #(
    parameter int MSHR_ENTRIES = 4,
    parameter int REQ_LANES    = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [REQ_LANES-1:0]              req_valid,
    input  logic [REQ_LANES-1:0][31:0]        req_addr,
    input  logic                              flush,
    output logic [$clog2(MSHR_ENTRIES):0]     free_slots,
    output logic                              mem_req_valid,
    output logic [31:0]                       mem_req_addr,
    output logic [1:0]                        mem_req_command,
    input  logic [3:0]                        mem_transaction_tag,
    input  logic [63:0]                       mem_data,
    input  logic [3:0]                        mem_data_tag,
    output logic                              fill_valid,
    output logic [31:0]                       fill_addr,
    output logic [63:0]                       fill_data
);

    localparam int IDX_W = (MSHR_ENTRIES > 1) ? $clog2(MSHR_ENTRIES) : 1;
    localparam int CNT_W = $clog2(MSHR_ENTRIES) + 1;

    localparam logic [1:0] ST_FREE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_ISSUED  = 2'd2;

    localparam logic [1:0] MEM_NONE = 2'd0;
    localparam logic [1:0] MEM_LOAD = 2'd1;

    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFF8;

    logic [1:0]  state_q [MSHR_ENTRIES];
    logic [1:0]  state_d [MSHR_ENTRIES];
    logic [31:0] addr_q  [MSHR_ENTRIES];
    logic [31:0] addr_d  [MSHR_ENTRIES];
    logic [3:0]  tag_q   [MSHR_ENTRIES];
    logic [3:0]  tag_d   [MSHR_ENTRIES];

    logic        fill_valid_q, fill_valid_d;
    logic [31:0] fill_addr_q,  fill_addr_d;
    logic [63:0] fill_data_q,  fill_data_d;

    logic [31:0]             line_addr [REQ_LANES];
    logic [REQ_LANES-1:0]    lane_merge;
    logic                    pend_found;
    logic [IDX_W-1:0]        pend_idx;
    logic                    ret_found;
    logic [IDX_W-1:0]        ret_idx;
    logic [CNT_W-1:0]        free_cnt;
    logic [MSHR_ENTRIES-1:0] taken;
    logic                    placed;

    always_comb begin
        for (int l = 0; l < REQ_LANES; l++) begin
            line_addr[l] = req_addr[l] & LINE_MASK;
        end
    end

    // Lowest-index PENDING entry feeds the memory port; a data tag selects
    // the ISSUED entry it completes.
    always_comb begin
        pend_found = 1'b0;
        pend_idx   = '0;
        ret_found  = 1'b0;
        ret_idx    = '0;
        free_cnt   = '0;
        for (int i = 0; i < MSHR_ENTRIES; i++) begin
            if (!pend_found && state_q[i] == ST_PENDING) begin
                pend_found = 1'b1;
                pend_idx   = IDX_W'(i);
            end
            if (!ret_found && state_q[i] == ST_ISSUED &&
                mem_data_tag != 4'd0 && tag_q[i] == mem_data_tag) begin
                ret_found = 1'b1;
                ret_idx   = IDX_W'(i);
            end
            if (state_q[i] == ST_FREE) begin
                free_cnt = free_cnt + CNT_W'(1);
            end
        end
    end

    assign free_slots      = free_cnt;
    assign mem_req_valid   = pend_found & ~flush;
    assign mem_req_addr    = mem_req_valid ? addr_q[pend_idx] : 32'd0;
    assign mem_req_command = mem_req_valid ? MEM_LOAD : MEM_NONE;

    // A lane merges into any live entry (including one whose data returns
    // this cycle) or into an identical lower-numbered lane.
    always_comb begin
        lane_merge = '0;
        for (int l = 0; l < REQ_LANES; l++) begin
            for (int i = 0; i < MSHR_ENTRIES; i++) begin
                if (state_q[i] != ST_FREE && addr_q[i] == line_addr[l]) begin
                    lane_merge[l] = 1'b1;
                end
            end
            for (int k = 0; k < REQ_LANES; k++) begin
                if (k < l && req_valid[k] && line_addr[k] == line_addr[l]) begin
                    lane_merge[l] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        tag_d        = tag_q;
        taken        = '0;
        placed       = 1'b0;
        fill_valid_d = ret_found;
        fill_addr_d  = fill_addr_q;
        fill_data_d  = fill_data_q;

        if (ret_found) begin
            state_d[ret_idx] = ST_FREE;
            fill_addr_d      = addr_q[ret_idx];
            fill_data_d      = mem_data;
        end

        if (mem_req_valid && mem_transaction_tag != 4'd0) begin
            state_d[pend_idx] = ST_ISSUED;
            tag_d[pend_idx]   = mem_transaction_tag;
        end

        if (flush) begin
            for (int i = 0; i < MSHR_ENTRIES; i++) begin
                if (state_q[i] == ST_PENDING) begin
                    state_d[i] = ST_FREE;
                end
            end
        end else begin
            // Only entries already FREE at the start of the cycle are candidates,
            // so a slot released by a returning fill waits one cycle.
            for (int l = 0; l < REQ_LANES; l++) begin
                placed = 1'b0;
                if (req_valid[l] && !lane_merge[l]) begin
                    for (int i = 0; i < MSHR_ENTRIES; i++) begin
                        if (!placed && state_q[i] == ST_FREE && !taken[i]) begin
                            taken[i]   = 1'b1;
                            placed     = 1'b1;
                            state_d[i] = ST_PENDING;
                            addr_d[i]  = line_addr[l];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MSHR_ENTRIES; i++) begin
                state_q[i] <= ST_FREE;
                addr_q[i]  <= '0;
                tag_q[i]   <= '0;
            end
            fill_valid_q <= 1'b0;
            fill_addr_q  <= '0;
            fill_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            tag_q        <= tag_d;
            fill_valid_q <= fill_valid_d;
            fill_addr_q  <= fill_addr_d;
            fill_data_q  <= fill_data_d;
        end
    end

    assign fill_valid = fill_valid_q;
    assign fill_addr  = fill_addr_q;
    assign fill_data  = fill_data_q;

endmodule
`default_nettype wire

// File: doc/icache_mshr.md
ICACHE_MSHR -- requirements
Module: icache_mshr

Interface
REQ-001 Parameter MSHR_ENTRIES, default 4, number of outstanding line-request entries.
REQ-002 Parameter REQ_LANES, default 2, request lanes per cycle (superscalar fetch width).
REQ-003 clock  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state.
REQ-005 req_valid  in  REQ_LANES  per-lane miss/prefetch request valid.
REQ-006 req_addr  in  REQ_LANES x 32  line address per lane; bits [2:0] ignored.
REQ-007 flush  in  1  drop all not-yet-issued entries (prefetch redirect).
REQ-008 free_slots  out  $clog2(MSHR_ENTRIES)+1  count of FREE entries, registered-state derived.
REQ-009 mem_req_valid  out  1  memory load request valid.
REQ-010 mem_req_addr  out  32  line address of request, bits [2:0] zero.
REQ-011 mem_req_command  out  2  MEM_LOAD when mem_req_valid, else MEM_NONE.
REQ-012 mem_transaction_tag  in  4  tag granted this cycle; 0 = rejected.
REQ-013 mem_data  in  64  returned block.
REQ-014 mem_data_tag  in  4  tag of returned block; 0 = no data.
REQ-015 fill_valid  out  1  icache write valid (registered).
REQ-016 fill_addr  out  32  line address of fill (registered).
REQ-017 fill_data  out  64  block written to icache (registered).

Function
REQ-018 Each entry SHALL hold state {FREE, PENDING, ISSUED}, 32-bit line address, 4-bit memory tag.
REQ-019 Allocation: valid lane whose line address matches any non-FREE entry, or a lower-numbered valid lane in the same cycle, SHALL be merged (dropped, no allocation).
REQ-020 Remaining lanes SHALL allocate lowest-index FREE entries in lane order, becoming PENDING at next edge; lanes exceeding available FREE entries SHALL be dropped silently.
REQ-021 Entry freed this cycle SHALL NOT be allocatable until next cycle.
REQ-022 mem_req_valid SHALL be combinationally asserted whenever any PENDING entry exists and flush is low; mem_req_addr = lowest-index PENDING entry's address.
REQ-023 Request-to-mem_req_valid latency SHALL be 1 cycle minimum.
REQ-024 Non-zero mem_transaction_tag while mem_req_valid SHALL move the selected entry to ISSUED with that tag at next edge; zero tag SHALL leave it PENDING for retry next cycle.
REQ-025 Non-zero mem_data_tag matching an ISSUED entry's tag SHALL produce fill_valid=1, fill_addr, fill_data next cycle and return that entry to FREE at the same edge.
REQ-026 mem_data_tag with no matching ISSUED entry SHALL be ignored; fill_valid=0.
REQ-027 Issue and data return on the same cycle for different entries SHALL both take effect.
REQ-028 Request matching an entry whose data returns this cycle SHALL be merged (fill already en route).
REQ-029 flush SHALL move all PENDING entries to FREE at next edge, retain ISSUED entries (their fills still delivered), ignore req_valid that cycle, and hold mem_req_valid low that cycle.
REQ-030 free_slots SHALL equal MSHR_ENTRIES minus non-FREE entries, never exceed MSHR_ENTRIES.
REQ-031 fill_valid SHALL be high at most one cycle per returned tag.

Reset
REQ-032 On reset assertion, asynchronously: all entries FREE, fill_valid=0, fill_addr=0, fill_data=0, free_slots=MSHR_ENTRIES; mem_req_valid=0, mem_req_command=MEM_NONE.
REQ-033 Reset mid-transaction SHALL discard all ISSUED entries; later data with those tags SHALL be ignored.

Verification
REQ-034 Lane0 0x1000, lane1 0x1008, tag 3 granted cycle 1 -> mem_req_addr 0x1000 cycle 1, 0x1008 cycle 2; free_slots 4->2.
REQ-035 Both lanes 0x2000 same cycle -> one entry allocated, free_slots 3; second request 0x2000 next cycle merged.
REQ-036 mem_transaction_tag=0 for 3 cycles then 5 -> mem_req_addr held constant, entry ISSUED tag 5 after grant.
REQ-037 Data tag 5 returns, data 0xDEADBEEF_CAFEF00D -> fill_valid one cycle later with matching addr/data; free_slots increments same edge.
REQ-038 Fill all 4 entries, request 2 more -> both dropped, free_slots 0; flush with 2 PENDING/2 ISSUED -> free_slots 2, ISSUED fills still arrive.
REQ-039 Assert reset with 2 ISSUED entries, then return their tags -> fill_valid stays 0, free_slots 4.
